br_resolve: RTL and testbench
=============================

# br_resolve

Pipeline-side partner of the branch predictor. Drives predictor lookups at fetch and records each prediction in an in-flight queue. At execute it checks each prediction against the resolved outcome, issues a predictor update for every resolved beq/bne, and raises a one-cycle flush/redirect on any misprediction. It sits between the IF/EX stages of the CPU and the predictor's read and write ports.

## Interface
Parameters:
- DEPTH, 4: in-flight queue entries (power of two, ≥2).
- CNT_W, 16: width of the statistics counters.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- if_valid_i  in  1  fetch slot holds an instruction.
- if_stall_i  in  1  fetch held this cycle; no push.
- if_pc_i  in  32  fetch PC.
- pred_addr_o  out  32  predictor read address; combinational copy of if_pc_i.
- pred_hit_i  in  1  predictor hit, meaning predicted taken.
- pred_target_i  in  32  predicted target.
- ex_valid_i  in  1  oldest in-flight instruction resolves this cycle.
- ex_beq_i, ex_bne_i  in  1 each  resolving instruction is beq or bne (at most one set).
- ex_taken_i  in  1  actual direction; ignored if not a branch.
- ex_target_i  in  32  actual taken target.
- upd_beq_o, upd_bne_o  out  1 each  update qualifiers to the predictor.
- upd_taken_o  out  1  update direction.
- upd_addr_o  out  32  PC of the resolved branch.
- upd_target_o  out  32  actual target.
- flush_o  out  1  misprediction; squash all younger work.
- redirect_pc_o  out  32  correct next PC; valid while flush_o=1.
- err_o  out  1  sticky protocol error.
- br_cnt_o  out  CNT_W  resolved branches, saturating.
- miss_cnt_o  out  CNT_W  mispredictions, saturating.

## Operation
- Queue entry: {pc[31:0], ptaken, ptarget[31:0]}. Circular buffer with wr_ptr, rd_ptr and count, width clog2(DEPTH)+1 for count.
- Push: if_valid_i & ~if_stall_i & ~flush_o. The entry captured is {if_pc_i, pred_hit_i, pred_target_i}.
- Pop: every ex_valid_i with count>0. The entry popped is the one at rd_ptr.
- Push and pop in the same cycle: both occur and count is unchanged. The pointers wrap modulo DEPTH.
- Push when full, with no simultaneous pop: entry dropped and err_o is set.
- ex_valid_i when empty: ignored and err_o is set.
- Resolution (br = ex_beq_i|ex_bne_i; pc4 = pc+4, mod 2^32):
  - br & ex_taken_i & (~ptaken | ptarget≠ex_target_i): miss, redirect = ex_target_i.
  - br & ~ex_taken_i & ptaken: miss, redirect = pc4.
  - ~br & ptaken (false hit on a non-branch): miss, redirect = pc4. No predictor update is issued.
  - All other cases: no miss.
- Update: every popped br issues one update with upd_beq_o/upd_bne_o copying the type, upd_taken_o=ex_taken_i, upd_addr_o=pc, upd_target_o=ex_target_i. A non-branch drives both qualifiers 0.
- Miss: next cycle, flush_o=1 and redirect_pc_o is driven. In that same cycle the queue is cleared (count=0, wr_ptr=rd_ptr=0), and pushes and ex_valid_i are ignored without setting err_o.
- Counters: br_cnt_o increments per resolved branch and miss_cnt_o per miss. Both saturate at all-ones.
- err_o clears only on rst.

## Timing
- Reset: all outputs 0 except pred_addr_o, which follows if_pc_i. The queue is emptied and the counters are zeroed.
- pred_addr_o: combinational, same cycle.
- Prediction capture: in the push cycle.
- upd_* and flush_o/redirect_pc_o: registered, valid exactly one cycle after ex_valid_i. upd_* qualifiers, flush_o and redirect_pc_o are single-cycle pulses; upd_* qualifiers are 0 otherwise.
- Back-to-back resolutions give back-to-back updates, with no bubbles.
- Counters update in the same edge as the outputs.
- rst mid-flush: reset wins and flush_o is 0 the next cycle.

## Structure
- The shared package `br_pkg` holds:
  - the S_NONTAKEN..S_TAKEN encodings, shared with the predictor;
  - the entry struct/width constants;
  - PC_STEP=4.
- One sub-module, `br_inflight_fifo` (parameterized DEPTH/width, with a synchronous clear). The compare/redirect logic and the counters live in the top module.

## Test plan
- Predicted not-taken beq at PC 0x100, resolves not-taken → upd_beq_o=1, upd_taken_o=0, upd_addr_o=0x100; flush_o=0; br_cnt_o=1.
- pred_hit_i=0 at PC 0x200; bne resolves taken, target 0x240 → next cycle flush_o=1, redirect_pc_o=0x240, miss_cnt_o=1, queue empty; a push in the flush cycle is dropped.
- Predicted taken to 0x300 at PC 0x2FC; resolves not-taken → redirect_pc_o=0x300 (pc+4). Predicted target 0x400 vs actual 0x404 → miss, redirect_pc_o=0x404.
- Non-branch at PC 0xFFFFFFFC with pred_hit_i=1 → flush, redirect_pc_o=0x00000000 (wrap), no upd_* pulse, br_cnt_o unchanged.
- Fill the queue to DEPTH=4, then push again without a pop → err_o=1 and stays 1. Simultaneous push and pop at full → no error, FIFO order preserved across pointer wrap.
- Preload miss_cnt_o near 0xFFFF via repeated misses → holds 0xFFFF. rst mid-operation → all counters 0, err_o=0, flush_o=0.

Source files
------------

// File: rtl/br_pkg.sv
// Shared definitions for the branch predictor and its pipeline-side resolver.
//   - bp_state_e : 2-bit direction counter encodings, shared with the predictor.
//   - br_entry_t : one in-flight prediction record {pc, ptaken, ptarget}.
//   - ENTRY_W    : packed width of br_entry_t.
//   - PC_STEP    : fall-through PC increment.
package br_pkg;

   typedef enum logic [1:0] {
      S_NONTAKEN = 2'b00,
      S_WEAK_NT  = 2'b01,
      S_WEAK_T   = 2'b10,
      S_TAKEN    = 2'b11
   } bp_state_e;

   localparam logic [31:0] PC_STEP = 32'd4;

   typedef struct packed {
      logic [31:0] pc;
      logic        ptaken;
      logic [31:0] ptarget;
   } br_entry_t;

   localparam int ENTRY_W = $bits(br_entry_t);

endpackage

// File: rtl/br_inflight_fifo.sv
// Circular in-flight queue with a synchronous clear.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   clr           empties the queue (pointers and count to 0)
//   push, wdata   write request and data; accepted when not full, or when
//                 a pop happens in the same cycle
//   pop           read-advance request; accepted when not empty
//   rdata         entry at the read pointer (combinational read)
//   full, empty   occupancy flags
module br_inflight_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 65
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push_en, pop_en;

   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);
   assign rdata = mem_q[rd_ptr_q];

   always_comb begin
      pop_en   = pop & ~empty;
      // A pop in the same cycle frees the slot, so a full queue can still accept.
      push_en  = push & (~full | pop_en);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clr) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         // DEPTH is a power of two, so pointers wrap by natural overflow.
         if (push_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop_en)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         if (push_en & ~pop_en) count_d = count_q + CNT_W'(1);
         if (pop_en & ~push_en) count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_en & ~clr) mem_q[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/br_resolve.sv
// Pipeline-side partner of the branch predictor.
// Drives predictor lookups from fetch, queues each prediction, checks it
// against the execute-stage outcome, issues predictor updates for beq/bne,
// and raises a one-cycle flush/redirect on a misprediction.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   if_valid_i/if_stall_i/if_pc_i  fetch slot
//   pred_addr_o                  predictor read address (= if_pc_i)
//   pred_hit_i/pred_target_i     predictor response (hit = predicted taken)
//   ex_valid_i/ex_beq_i/ex_bne_i/ex_taken_i/ex_target_i  execute resolution
//   upd_*_o                      registered predictor update
//   flush_o/redirect_pc_o        registered misprediction pulse and next PC
//   err_o                        sticky protocol error
//   br_cnt_o/miss_cnt_o          saturating statistics
module br_resolve
   import br_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             if_valid_i,
   input  logic             if_stall_i,
   input  logic [31:0]      if_pc_i,
   output logic [31:0]      pred_addr_o,
   input  logic             pred_hit_i,
   input  logic [31:0]      pred_target_i,
   input  logic             ex_valid_i,
   input  logic             ex_beq_i,
   input  logic             ex_bne_i,
   input  logic             ex_taken_i,
   input  logic [31:0]      ex_target_i,
   output logic             upd_beq_o,
   output logic             upd_bne_o,
   output logic             upd_taken_o,
   output logic [31:0]      upd_addr_o,
   output logic [31:0]      upd_target_o,
   output logic             flush_o,
   output logic [31:0]      redirect_pc_o,
   output logic             err_o,
   output logic [CNT_W-1:0] br_cnt_o,
   output logic [CNT_W-1:0] miss_cnt_o
);

   br_entry_t  wr_entry, head;
   logic       fifo_full, fifo_empty;
   logic       push_req, ex_req, ex_fire, br, miss;
   logic [31:0] pc4, redir;

   logic             upd_beq_q, upd_beq_d;
   logic             upd_bne_q, upd_bne_d;
   logic             upd_taken_q, upd_taken_d;
   logic [31:0]      upd_addr_q, upd_addr_d;
   logic [31:0]      upd_target_q, upd_target_d;
   logic             flush_q, flush_d;
   logic [31:0]      redirect_q, redirect_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
   logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

   assign pred_addr_o = if_pc_i;
   assign wr_entry    = '{pc: if_pc_i, ptaken: pred_hit_i, ptarget: pred_target_i};

   br_inflight_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .clr   (flush_q),
      .push  (push_req),
      .pop   (ex_fire),
      .wdata (wr_entry),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_comb begin
      // While flushing, fetch and execute traffic belong to squashed work.
      push_req = if_valid_i & ~if_stall_i & ~flush_q;
      ex_req   = ex_valid_i & ~flush_q;
      ex_fire  = ex_req & ~fifo_empty;
      br       = ex_beq_i | ex_bne_i;
      pc4      = head.pc + PC_STEP;

      miss  = 1'b0;
      redir = '0;
      if (br & ex_taken_i & (~head.ptaken | (head.ptarget != ex_target_i))) begin
         miss  = 1'b1;
         redir = ex_target_i;
      end else if (head.ptaken & ~(br & ex_taken_i)) begin
         // Predicted taken but fell through: covers not-taken branches and
         // false hits on non-branch instructions.
         miss  = 1'b1;
         redir = pc4;
      end

      flush_d    = ex_fire & miss;
      redirect_d = flush_d ? redir : '0;

      upd_beq_d    = ex_fire & ex_beq_i;
      upd_bne_d    = ex_fire & ex_bne_i;
      upd_taken_d  = ex_fire & br & ex_taken_i;
      upd_addr_d   = upd_addr_q;
      upd_target_d = upd_target_q;
      if (ex_fire & br) begin
         upd_addr_d   = head.pc;
         upd_target_d = ex_target_i;
      end

      err_d = err_q | (push_req & fifo_full & ~ex_fire) | (ex_req & fifo_empty);

      br_cnt_d   = br_cnt_q;
      miss_cnt_d = miss_cnt_q;
      if (ex_fire & br & ~(&br_cnt_q))  br_cnt_d   = br_cnt_q + CNT_W'(1);
      if (flush_d & ~(&miss_cnt_q))     miss_cnt_d = miss_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         upd_beq_q    <= 1'b0;
         upd_bne_q    <= 1'b0;
         upd_taken_q  <= 1'b0;
         upd_addr_q   <= '0;
         upd_target_q <= '0;
         flush_q      <= 1'b0;
         redirect_q   <= '0;
         err_q        <= 1'b0;
         br_cnt_q     <= '0;
         miss_cnt_q   <= '0;
      end else begin
         upd_beq_q    <= upd_beq_d;
         upd_bne_q    <= upd_bne_d;
         upd_taken_q  <= upd_taken_d;
         upd_addr_q   <= upd_addr_d;
         upd_target_q <= upd_target_d;
         flush_q      <= flush_d;
         redirect_q   <= redirect_d;
         err_q        <= err_d;
         br_cnt_q     <= br_cnt_d;
         miss_cnt_q   <= miss_cnt_d;
      end
   end

   assign upd_beq_o     = upd_beq_q;
   assign upd_bne_o     = upd_bne_q;
   assign upd_taken_o   = upd_taken_q;
   assign upd_addr_o    = upd_addr_q;
   assign upd_target_o  = upd_target_q;
   assign flush_o       = flush_q;
   assign redirect_pc_o = redirect_q;
   assign err_o         = err_q;
   assign br_cnt_o      = br_cnt_q;
   assign miss_cnt_o    = miss_cnt_q;

endmodule

// File: tb/tb_br_resolve.sv
// Self-checking bench for br_resolve: a table of single push/resolve
// transactions followed by hand-written multi-cycle sequences (flush drop,
// full queue with wrap, error stickiness, counter saturation, reset mid-miss).
module tb_br_resolve;

   localparam int DEPTH = 4;
   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             if_valid_i, if_stall_i;
   logic [31:0]      if_pc_i;
   logic [31:0]      pred_addr_o;
   logic             pred_hit_i;
   logic [31:0]      pred_target_i;
   logic             ex_valid_i, ex_beq_i, ex_bne_i, ex_taken_i;
   logic [31:0]      ex_target_i;
   logic             upd_beq_o, upd_bne_o, upd_taken_o;
   logic [31:0]      upd_addr_o, upd_target_o;
   logic             flush_o;
   logic [31:0]      redirect_pc_o;
   logic             err_o;
   logic [CNT_W-1:0] br_cnt_o, miss_cnt_o;

   int checks = 0;
   int errors = 0;

   br_resolve #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk           (clk),
      .rst           (rst),
      .if_valid_i    (if_valid_i),
      .if_stall_i    (if_stall_i),
      .if_pc_i       (if_pc_i),
      .pred_addr_o   (pred_addr_o),
      .pred_hit_i    (pred_hit_i),
      .pred_target_i (pred_target_i),
      .ex_valid_i    (ex_valid_i),
      .ex_beq_i      (ex_beq_i),
      .ex_bne_i      (ex_bne_i),
      .ex_taken_i    (ex_taken_i),
      .ex_target_i   (ex_target_i),
      .upd_beq_o     (upd_beq_o),
      .upd_bne_o     (upd_bne_o),
      .upd_taken_o   (upd_taken_o),
      .upd_addr_o    (upd_addr_o),
      .upd_target_o  (upd_target_o),
      .flush_o       (flush_o),
      .redirect_pc_o (redirect_pc_o),
      .err_o         (err_o),
      .br_cnt_o      (br_cnt_o),
      .miss_cnt_o    (miss_cnt_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic        hit;
      logic [31:0] ptgt;
      logic        beq;
      logic        bne;
      logic        taken;
      logic [31:0] tgt;
      logic        e_ubeq;
      logic        e_ubne;
      logic        e_utaken;
      logic        e_flush;
      logic [31:0] e_redir;
   } vec_t;

   localparam int NVEC = 8;
   vec_t vecs [NVEC];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Advance one clock; outputs are sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      if_valid_i = 1'b0; if_stall_i = 1'b0; if_pc_i = '0;
      pred_hit_i = 1'b0; pred_target_i = '0;
      ex_valid_i = 1'b0; ex_beq_i = 1'b0; ex_bne_i = 1'b0;
      ex_taken_i = 1'b0; ex_target_i = '0;
   endtask

   task automatic set_push(input logic [31:0] pc, input logic hit, input logic [31:0] ptgt);
      if_valid_i = 1'b1; if_pc_i = pc; pred_hit_i = hit; pred_target_i = ptgt;
   endtask

   task automatic set_ex(input logic beq, input logic bne, input logic taken, input logic [31:0] tgt);
      ex_valid_i = 1'b1; ex_beq_i = beq; ex_bne_i = bne; ex_taken_i = taken; ex_target_i = tgt;
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   int exp_br, exp_miss;

   initial begin
      //                pc            hit ptgt          beq bne tk tgt           ub un ut fl redir
      vecs[0] = '{32'h0000_0100, 1'b0, 32'h0,        1'b1,1'b0,1'b0,32'h0000_0180, 1'b1,1'b0,1'b0,1'b0,32'h0};
      vecs[1] = '{32'h0000_0200, 1'b0, 32'h0,        1'b0,1'b1,1'b1,32'h0000_0240, 1'b0,1'b1,1'b1,1'b1,32'h0000_0240};
      vecs[2] = '{32'h0000_02FC, 1'b1, 32'h0000_0300,1'b1,1'b0,1'b0,32'h0000_0300, 1'b1,1'b0,1'b0,1'b1,32'h0000_0300};
      vecs[3] = '{32'h0000_03F0, 1'b1, 32'h0000_0400,1'b0,1'b1,1'b1,32'h0000_0404, 1'b0,1'b1,1'b1,1'b1,32'h0000_0404};
      vecs[4] = '{32'hFFFF_FFFC, 1'b1, 32'h0000_0010,1'b0,1'b0,1'b1,32'h0000_0050, 1'b0,1'b0,1'b0,1'b1,32'h0000_0000};
      vecs[5] = '{32'h0000_0500, 1'b1, 32'h0000_0600,1'b1,1'b0,1'b1,32'h0000_0600, 1'b1,1'b0,1'b1,1'b0,32'h0};
      vecs[6] = '{32'h0000_0700, 1'b0, 32'h0,        1'b0,1'b0,1'b0,32'h0000_0000, 1'b0,1'b0,1'b0,1'b0,32'h0};
      vecs[7] = '{32'h0000_0800, 1'b1, 32'h0000_0900,1'b0,1'b1,1'b1,32'h0000_0900, 1'b0,1'b1,1'b1,1'b0,32'h0};

      do_reset();

      // Reset state; pred_addr_o follows fetch PC combinationally.
      if_pc_i = 32'h1234_5678;
      #1;
      chk("rst_pred_addr", pred_addr_o, 32'h1234_5678);
      chk("rst_upd_beq", {31'b0, upd_beq_o}, 32'd0);
      chk("rst_upd_bne", {31'b0, upd_bne_o}, 32'd0);
      chk("rst_flush", {31'b0, flush_o}, 32'd0);
      chk("rst_redirect", redirect_pc_o, 32'd0);
      chk("rst_err", {31'b0, err_o}, 32'd0);
      chk("rst_br_cnt", 32'(br_cnt_o), 32'd0);
      chk("rst_miss_cnt", 32'(miss_cnt_o), 32'd0);
      idle();

      // Table-driven single transactions.
      exp_br = 0;
      exp_miss = 0;
      for (int v = 0; v < NVEC; v++) begin
         set_push(vecs[v].pc, vecs[v].hit, vecs[v].ptgt);
         #1;
         chk("vec_pred_addr", pred_addr_o, vecs[v].pc);
         tick();
         if_valid_i = 1'b0;
         set_ex(vecs[v].beq, vecs[v].bne, vecs[v].taken, vecs[v].tgt);
         tick();
         if (vecs[v].beq | vecs[v].bne) exp_br++;
         if (vecs[v].e_flush) exp_miss++;
         $display("vec %0d pc=%h upd_beq=%0d upd_bne=%0d flush=%0d redirect=%h br_cnt=%0d miss_cnt=%0d",
                  v, vecs[v].pc, upd_beq_o, upd_bne_o, flush_o, redirect_pc_o, br_cnt_o, miss_cnt_o);
         chk("vec_upd_beq", {31'b0, upd_beq_o}, {31'b0, vecs[v].e_ubeq});
         chk("vec_upd_bne", {31'b0, upd_bne_o}, {31'b0, vecs[v].e_ubne});
         if (vecs[v].beq | vecs[v].bne) begin
            chk("vec_upd_taken", {31'b0, upd_taken_o}, {31'b0, vecs[v].e_utaken});
            chk("vec_upd_addr", upd_addr_o, vecs[v].pc);
            chk("vec_upd_target", upd_target_o, vecs[v].tgt);
         end
         chk("vec_flush", {31'b0, flush_o}, {31'b0, vecs[v].e_flush});
         if (vecs[v].e_flush) chk("vec_redirect", redirect_pc_o, vecs[v].e_redir);
         chk("vec_br_cnt", 32'(br_cnt_o), 32'(exp_br));
         chk("vec_miss_cnt", 32'(miss_cnt_o), 32'(exp_miss));
         idle();
         tick();
         chk("vec_pulse_flush", {31'b0, flush_o}, 32'd0);
         chk("vec_pulse_upd", {30'b0, upd_beq_o, upd_bne_o}, 32'd0);
         chk("vec_err", {31'b0, err_o}, 32'd0);
      end

      // Miss clears the queue; push and ex_valid in the flush cycle are dropped silently.
      set_push(32'h0000_0A00, 1'b0, 32'h0);
      tick();
      set_push(32'h0000_0A04, 1'b0, 32'h0);
      set_ex(1'b0, 1'b1, 1'b1, 32'h0000_0B00);
      tick();
      $display("flush seq: flush=%0d redirect=%h", flush_o, redirect_pc_o);
      chk("fl_flush", {31'b0, flush_o}, 32'd1);
      chk("fl_redirect", redirect_pc_o, 32'h0000_0B00);
      set_push(32'h0000_0C00, 1'b0, 32'h0);
      set_ex(1'b1, 1'b0, 1'b0, 32'h0);
      tick();
      chk("fl_ex_ignored", {31'b0, upd_beq_o}, 32'd0);
      chk("fl_no_err", {31'b0, err_o}, 32'd0);
      idle();
      set_push(32'h0000_0D00, 1'b0, 32'h0);
      tick();
      idle();
      set_ex(1'b1, 1'b0, 1'b0, 32'h0000_0D80);
      tick();
      $display("post-flush resolve: upd_beq=%0d upd_addr=%h err=%0d", upd_beq_o, upd_addr_o, err_o);
      chk("fl_next_beq", {31'b0, upd_beq_o}, 32'd1);
      chk("fl_next_addr", upd_addr_o, 32'h0000_0D00);
      chk("fl_next_err", {31'b0, err_o}, 32'd0);
      idle();
      tick();

      // Fill to DEPTH, then push+pop at full, then drain back to back across the wrap.
      for (int i = 0; i < DEPTH; i++) begin
         set_push(32'h0000_1000 + 32'(4 * i), 1'b0, 32'h0);
         tick();
      end
      set_push(32'h0000_1000 + 32'(4 * DEPTH), 1'b0, 32'h0);
      set_ex(1'b1, 1'b0, 1'b0, 32'h0000_1F00);
      tick();
      $display("full push+pop: upd_addr=%h err=%0d", upd_addr_o, err_o);
      chk("pp_beq", {31'b0, upd_beq_o}, 32'd1);
      chk("pp_addr", upd_addr_o, 32'h0000_1000);
      chk("pp_err", {31'b0, err_o}, 32'd0);
      if_valid_i = 1'b0;
      for (int i = 1; i <= DEPTH; i++) begin
         tick();
         $display("drain %0d: upd_beq=%0d upd_addr=%h", i, upd_beq_o, upd_addr_o);
         chk("b2b_beq", {31'b0, upd_beq_o}, 32'd1);
         chk("b2b_addr", upd_addr_o, 32'h0000_1000 + 32'(4 * i));
      end
      idle();
      tick();
      chk("b2b_end_beq", {31'b0, upd_beq_o}, 32'd0);
      chk("b2b_end_err", {31'b0, err_o}, 32'd0);

      // Overflow: push when full without pop sets the sticky error and drops the entry.
      for (int i = 0; i < DEPTH; i++) begin
         set_push(32'h0000_2000 + 32'(4 * i), 1'b0, 32'h0);
         tick();
      end
      chk("ovf_err_before", {31'b0, err_o}, 32'd0);
      set_push(32'h0000_2000 + 32'(4 * DEPTH), 1'b0, 32'h0);
      tick();
      $display("overflow push: err=%0d", err_o);
      chk("ovf_err", {31'b0, err_o}, 32'd1);
      idle();
      set_ex(1'b1, 1'b0, 1'b0, 32'h0);
      for (int i = 0; i < DEPTH; i++) begin
         tick();
         chk("ovf_drain_addr", upd_addr_o, 32'h0000_2000 + 32'(4 * i));
      end
      // Queue now empty: the dropped entry must not appear.
      tick();
      chk("ovf_dropped", {31'b0, upd_beq_o}, 32'd0);
      chk("ovf_err_sticky", {31'b0, err_o}, 32'd1);
      idle();
      tick();
      tick();
      chk("ovf_err_sticky2", {31'b0, err_o}, 32'd1);

      // ex_valid on an empty queue.
      do_reset();
      chk("empty_err_clr", {31'b0, err_o}, 32'd0);
      set_ex(1'b0, 1'b1, 1'b1, 32'h0000_0040);
      tick();
      $display("ex on empty: err=%0d upd_bne=%0d", err_o, upd_bne_o);
      chk("empty_err", {31'b0, err_o}, 32'd1);
      chk("empty_no_upd", {31'b0, upd_bne_o}, 32'd0);
      chk("empty_no_br", 32'(br_cnt_o), 32'd0);
      idle();

      // Counter saturation: repeated bne mispredictions.
      do_reset();
      for (int n = 0; n < 260; n++) begin
         set_push(32'h0000_3000, 1'b0, 32'h0);
         tick();
         if_valid_i = 1'b0;
         set_ex(1'b0, 1'b1, 1'b1, 32'h0000_3100);
         tick();
         idle();
         tick();
         if (n == 253) chk("sat_miss_254", 32'(miss_cnt_o), 32'd254);
      end
      $display("saturation: br_cnt=%h miss_cnt=%h", br_cnt_o, miss_cnt_o);
      chk("sat_miss", 32'(miss_cnt_o), 32'h0000_00FF);
      chk("sat_br", 32'(br_cnt_o), 32'h0000_00FF);
      set_push(32'h0000_3200, 1'b0, 32'h0);
      tick();
      if_valid_i = 1'b0;
      set_ex(1'b1, 1'b0, 1'b0, 32'h0000_3300);
      tick();
      chk("sat_br_hold", 32'(br_cnt_o), 32'h0000_00FF);
      chk("sat_miss_hold", 32'(miss_cnt_o), 32'h0000_00FF);
      chk("sat_no_flush", {31'b0, flush_o}, 32'd0);
      idle();
      tick();

      // Reset asserted on the resolving edge of a miss: reset wins.
      set_ex(1'b1, 1'b0, 1'b0, 32'h0);   // empty queue -> err set
      tick();
      chk("rm_err_set", {31'b0, err_o}, 32'd1);
      idle();
      set_push(32'h0000_4000, 1'b0, 32'h0);
      tick();
      if_valid_i = 1'b0;
      set_ex(1'b0, 1'b1, 1'b1, 32'h0000_4400);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      idle();
      $display("reset mid-miss: flush=%0d err=%0d br_cnt=%0d miss_cnt=%0d", flush_o, err_o, br_cnt_o, miss_cnt_o);
      chk("rm_flush", {31'b0, flush_o}, 32'd0);
      chk("rm_upd", {31'b0, upd_bne_o}, 32'd0);
      chk("rm_err", {31'b0, err_o}, 32'd0);
      chk("rm_br_cnt", 32'(br_cnt_o), 32'd0);
      chk("rm_miss_cnt", 32'(miss_cnt_o), 32'd0);
      tick();
      chk("rm_flush_after", {31'b0, flush_o}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
